// File: rtl/fetch_queue_if.sv
// Fetch/dispatch side of the two-wide fetch queue: enqueue pair, dequeue enables, head/head+1 view.
// master drives fetch/dispatch controls; slave is the queue itself.
interface fetch_queue_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          enq_valid_0;
  logic          enq_valid_1;
  logic [31:0]   enq_insn_0;
  logic [31:0]   enq_insn_1;
  logic [63:0]   enq_npc_0;
  logic [63:0]   enq_npc_1;
  logic          enq_br_taken_0;
  logic          enq_br_taken_1;
  logic [63:0]   enq_target;
  logic          deq_en_0;
  logic          deq_en_1;
  logic          out_valid_0;
  logic          out_valid_1;
  logic [31:0]   out_insn_0;
  logic [31:0]   out_insn_1;
  logic [63:0]   out_npc_0;
  logic [63:0]   out_npc_1;
  logic          out_br_taken_0;
  logic          out_br_taken_1;
  logic [63:0]   out_target_0;
  logic [63:0]   out_target_1;
  logic          fq_stall;
  logic [CW-1:0] fq_count;

  modport master (
    output flush,
    output enq_valid_0, enq_valid_1, enq_insn_0, enq_insn_1,
    output enq_npc_0, enq_npc_1, enq_br_taken_0, enq_br_taken_1, enq_target,
    output deq_en_0, deq_en_1,
    input  out_valid_0, out_valid_1, out_insn_0, out_insn_1,
    input  out_npc_0, out_npc_1, out_br_taken_0, out_br_taken_1,
    input  out_target_0, out_target_1, fq_stall, fq_count
  );

  modport slave (
    input  flush,
    input  enq_valid_0, enq_valid_1, enq_insn_0, enq_insn_1,
    input  enq_npc_0, enq_npc_1, enq_br_taken_0, enq_br_taken_1, enq_target,
    input  deq_en_0, deq_en_1,
    output out_valid_0, out_valid_1, out_insn_0, out_insn_1,
    output out_npc_0, out_npc_1, out_br_taken_0, out_br_taken_1,
    output out_target_0, out_target_1, fq_stall, fq_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-wide circular instruction buffer; entries visible one cycle after enqueue, dequeue at the edge.
// Fetch is held off (fq_stall) whenever fewer than two entries are free; flush empties in one cycle.
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.slave  fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   insn_mem   [DEPTH];
  logic [63:0]   npc_mem    [DEPTH];
  logic          br_mem     [DEPTH];
  logic [63:0]   target_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [PW-1:0] head_next1;
  logic [PW-1:0] slot1_addr;
  logic          stall;
  logic          deq_0;
  logic          deq_1;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;

  // Registered count only: a same-cycle dequeue does not release the stall.
  assign stall = (count > CW'(DEPTH - 2));

  assign enq_n = stall ? 2'd0 : ({1'b0, fq.enq_valid_0} + {1'b0, fq.enq_valid_1});

  assign deq_0 = fq.deq_en_0 && (count != '0);
  assign deq_1 = deq_0 && fq.deq_en_1 && (count >= CW'(2));
  assign deq_n = {1'b0, deq_0} + {1'b0, deq_1};

  assign head_next1 = head + PW'(1);
  // A lone slot-1 instruction is compacted into the tail entry.
  assign slot1_addr = fq.enq_valid_0 ? (tail + PW'(1)) : tail;

  always_ff @(posedge clock) begin
    if (!reset && !fq.flush && !stall) begin
      if (fq.enq_valid_0) begin
        insn_mem[tail]   <= fq.enq_insn_0;
        npc_mem[tail]    <= fq.enq_npc_0;
        br_mem[tail]     <= fq.enq_br_taken_0;
        target_mem[tail] <= fq.enq_target;
      end
      if (fq.enq_valid_1) begin
        insn_mem[slot1_addr]   <= fq.enq_insn_1;
        npc_mem[slot1_addr]    <= fq.enq_npc_1;
        br_mem[slot1_addr]     <= fq.enq_br_taken_1;
        target_mem[slot1_addr] <= fq.enq_target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || fq.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  assign fq.out_valid_0    = (count != '0);
  assign fq.out_valid_1    = (count >= CW'(2));
  assign fq.out_insn_0     = insn_mem[head];
  assign fq.out_insn_1     = insn_mem[head_next1];
  assign fq.out_npc_0      = npc_mem[head];
  assign fq.out_npc_1      = npc_mem[head_next1];
  assign fq.out_br_taken_0 = br_mem[head];
  assign fq.out_br_taken_1 = br_mem[head_next1];
  assign fq.out_target_0   = target_mem[head];
  assign fq.out_target_1   = target_mem[head_next1];
  assign fq.fq_stall       = stall;
  assign fq.fq_count       = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_queue;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] insn;
    logic [63:0] npc;
    logic        br;
    logic [63:0] target;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;
  bit model_ready = 1'b0;
  ent_t mq[$];
  logic [31:0] deq_log[$];

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .fq    (fq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order list of occupied entries.
  always @(posedge clock) begin : model
    int  n;
    bit  st;
    ent_t e;
    if (reset || fq.flush) begin
      mq.delete();
      model_ready = 1'b1;
    end else if (model_ready) begin
      st = (DEPTH - mq.size()) < 2;
      n = 0;
      if (fq.deq_en_0 && mq.size() >= 1) n = 1;
      if (fq.deq_en_0 && fq.deq_en_1 && mq.size() >= 2) n = 2;
      for (int i = 0; i < n; i++) begin
        e = mq.pop_front();
        deq_log.push_back(e.insn);
      end
      if (!st) begin
        if (fq.enq_valid_0) mq.push_back('{fq.enq_insn_0, fq.enq_npc_0, fq.enq_br_taken_0, fq.enq_target});
        if (fq.enq_valid_1) mq.push_back('{fq.enq_insn_1, fq.enq_npc_1, fq.enq_br_taken_1, fq.enq_target});
      end
    end
  end

  always @(negedge clock) begin
    if (model_ready) begin
      check("out_valid_0", fq.out_valid_0, mq.size() >= 1);
      check("out_valid_1", fq.out_valid_1, mq.size() >= 2);
      check("fq_count", fq.fq_count, mq.size());
      check("fq_stall", fq.fq_stall, (DEPTH - mq.size()) < 2);
      if (mq.size() >= 1) begin
        check("out_insn_0", fq.out_insn_0, mq[0].insn);
        check("out_npc_0", fq.out_npc_0, mq[0].npc);
        check("out_br_taken_0", fq.out_br_taken_0, mq[0].br);
        check("out_target_0", fq.out_target_0, mq[0].target);
      end
      if (mq.size() >= 2) begin
        check("out_insn_1", fq.out_insn_1, mq[1].insn);
        check("out_npc_1", fq.out_npc_1, mq[1].npc);
        check("out_br_taken_1", fq.out_br_taken_1, mq[1].br);
        check("out_target_1", fq.out_target_1, mq[1].target);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fq.flush       = 1'b0;
    fq.enq_valid_0 = 1'b0;
    fq.enq_valid_1 = 1'b0;
    fq.deq_en_0    = 1'b0;
    fq.deq_en_1    = 1'b0;
  endtask

  task automatic set_enq(input bit v0, input bit v1, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [63:0] n0, input logic [63:0] n1);
    fq.enq_valid_0    = v0;
    fq.enq_valid_1    = v1;
    fq.enq_insn_0     = i0;
    fq.enq_insn_1     = i1;
    fq.enq_npc_0      = n0;
    fq.enq_npc_1      = n1;
    fq.enq_br_taken_0 = i0[0];
    fq.enq_br_taken_1 = i1[1];
    fq.enq_target     = {32'hBEEF_0000, i0};
  endtask

  task automatic do_flush();
    idle();
    fq.flush = 1'b1;
    step();
    fq.flush = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;
    idle();
    set_enq(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);
    step();
    step();
    reset = 1'b0;
    check("rst_count", fq.fq_count, 0);
    check("rst_valid_0", fq.out_valid_0, 0);
    check("rst_valid_1", fq.out_valid_1, 0);
    check("rst_stall", fq.fq_stall, 0);

    // Two-wide enqueue into an empty queue
    set_enq(1'b1, 1'b1, 32'hA, 32'hB, 64'h104, 64'h108);
    step();
    idle();
    check("pair_valid_0", fq.out_valid_0, 1);
    check("pair_valid_1", fq.out_valid_1, 1);
    check("pair_insn_0", fq.out_insn_0, 32'hA);
    check("pair_insn_1", fq.out_insn_1, 32'hB);
    check("pair_npc_1", fq.out_npc_1, 64'h108);
    check("pair_target_1", fq.out_target_1, 64'hBEEF_0000_0000_000A);
    check("pair_count", fq.fq_count, 2);

    // Lone slot 1 is compacted to the head
    do_flush();
    check("flush_count", fq.fq_count, 0);
    set_enq(1'b0, 1'b1, 32'h0, 32'hC, 64'h0, 64'h200);
    step();
    idle();
    check("slot1_insn_0", fq.out_insn_0, 32'hC);
    check("slot1_valid_1", fq.out_valid_1, 0);
    check("slot1_count", fq.fq_count, 1);

    // Fill to DEPTH, then an ignored fifth enqueue
    do_flush();
    for (int k = 0; k < 4; k++) begin
      set_enq(1'b1, 1'b1, 32'h10 + 2*k, 32'h11 + 2*k, 64'h1000 + 8*k, 64'h1004 + 8*k);
      step();
    end
    check("full_stall", fq.fq_stall, 1);
    check("full_count", fq.fq_count, 8);
    set_enq(1'b1, 1'b1, 32'hFF, 32'hFE, 64'h0, 64'h0);
    step();
    check("full_ign_count", fq.fq_count, 8);
    check("full_ign_insn_0", fq.out_insn_0, 32'h10);
    check("full_ign_insn_1", fq.out_insn_1, 32'h11);

    // Full queue: double dequeue proceeds, enqueue dropped
    fq.deq_en_0 = 1'b1;
    fq.deq_en_1 = 1'b1;
    step();
    idle();
    check("full_deq_count", fq.fq_count, 6);
    check("full_deq_stall", fq.fq_stall, 0);
    check("full_deq_insn_0", fq.out_insn_0, 32'h12);

    // Streaming with wrap: two-wide enqueue, single dequeue, stall honoured
    do_flush();
    deq_log.delete();
    seq = 32'h100;
    for (int c = 0; c < 20; c++) begin
      if (!fq.fq_stall) begin
        set_enq(1'b1, 1'b1, seq, seq + 1, 64'h8000 + {32'h0, seq} * 4, 64'h8004 + {32'h0, seq} * 4);
        seq += 2;
      end else begin
        fq.enq_valid_0 = 1'b0;
        fq.enq_valid_1 = 1'b0;
      end
      fq.deq_en_0 = 1'b1;
      step();
    end
    idle();
    step();
    check("stream_deq_len", deq_log.size(), 19);
    for (int i = 0; i < deq_log.size(); i++)
      check("stream_order", deq_log[i], 32'h100 + i);

    // Flush beats a same-cycle enqueue and dequeue
    do_flush();
    set_enq(1'b1, 1'b1, 32'h40, 32'h41, 64'h0, 64'h4);
    step();
    set_enq(1'b1, 1'b1, 32'h42, 32'h43, 64'h8, 64'hC);
    step();
    set_enq(1'b1, 1'b0, 32'h44, 32'h0, 64'h10, 64'h0);
    step();
    idle();
    check("five_count", fq.fq_count, 5);
    fq.flush = 1'b1;
    set_enq(1'b1, 1'b1, 32'h50, 32'h51, 64'h0, 64'h0);
    fq.deq_en_0 = 1'b1;
    step();
    idle();
    check("flushed_count", fq.fq_count, 0);
    check("flushed_valid_0", fq.out_valid_0, 0);
    check("flushed_stall", fq.fq_stall, 0);
    set_enq(1'b1, 1'b1, 32'h55, 32'h56, 64'h20, 64'h24);
    step();
    idle();
    check("post_flush_count", fq.fq_count, 2);
    check("post_flush_insn_0", fq.out_insn_0, 32'h55);

    // One entry, double dequeue request plus a pair enqueue
    do_flush();
    set_enq(1'b1, 1'b0, 32'hD, 32'h0, 64'h300, 64'h0);
    step();
    deq_log.delete();
    set_enq(1'b1, 1'b1, 32'hE, 32'hF, 64'h304, 64'h308);
    fq.deq_en_0 = 1'b1;
    fq.deq_en_1 = 1'b1;
    step();
    idle();
    check("one_deq_len", deq_log.size(), 1);
    if (deq_log.size() >= 1) check("one_deq_insn", deq_log[0], 32'hD);
    check("one_deq_count", fq.fq_count, 2);
    check("one_deq_insn_0", fq.out_insn_0, 32'hE);
    check("one_deq_insn_1", fq.out_insn_1, 32'hF);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-wide circular instruction buffer between the branch predecode stage and dispatch. It captures up to two predecoded instructions per cycle, together with their NPCs and branch-prediction annotations, and presents the two oldest entries in program order to dispatch. It absorbs dispatch back-pressure by stalling fetch, and empties in one cycle on an execute-stage mispredict flush.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, at least 4.

Ports (clock and reset first):
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  mispredict or exception recovery; empties the queue.
- enq_valid_0  in  1  slot 0 valid (older).
- enq_valid_1  in  1  slot 1 valid (younger).
- enq_insn_0, enq_insn_1  in  32  instruction words.
- enq_npc_0, enq_npc_1  in  64  NPC of each instruction.
- enq_br_taken_0, enq_br_taken_1  in  1  predicted taken.
- enq_target  in  64  predicted target; shared by both slots.
- deq_en_0  in  1  dispatch consumes head entry.
- deq_en_1  in  1  dispatch consumes head+1 entry; legal only with deq_en_0.
- out_valid_0, out_valid_1  out  1  head / head+1 entry present.
- out_insn_0, out_insn_1  out  32  instruction words.
- out_npc_0, out_npc_1  out  64  NPCs.
- out_br_taken_0, out_br_taken_1  out  1  prediction bits.
- out_target_0, out_target_1  out  64  stored targets.
- fq_stall  out  1  fewer than 2 free entries; fetch must hold.
- fq_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: per entry {insn, npc, br_taken, target}. head and tail pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is held in a separate register.
- Enqueue is accepted only when fq_stall is 0.
  - Both slots valid: write slot 0 at tail and slot 1 at tail+1; tail advances by 2.
  - Only slot 0 valid: write it at tail; tail advances by 1.
  - Only slot 1 valid: compact it into tail; tail advances by 1.
  - Both slots invalid: no write.
- Enqueue while fq_stall is 1 is ignored. Fetch is responsible for holding its inputs.
- Dequeue:
  - deq_en_0 advances head by 1, or by 2 when deq_en_1 is also set.
  - A dequeue request beyond out_valid is ignored per slot. deq_en_1 without deq_en_0 is ignored.
- Simultaneous enqueue and dequeue: count_next = count + enq_n − deq_n. Both are allowed in the same cycle.
- fq_stall = (DEPTH − count) < 2. It uses the registered count only, not the same-cycle dequeue, so it is conservative.
- out_valid_0 = count ≥ 1; out_valid_1 = count ≥ 2. Outputs are read combinationally from head and head+1, with head+1 wrapping.
- Output data of invalid slots is don't-care. The bench checks it only when the slot is valid.
- flush: head, tail and count go to 0 next cycle. Enqueue and dequeue in the same cycle are discarded. flush has priority over everything except reset.
- reset: same effect as flush. Entry storage is not cleared.

## Timing
- Reset values: out_valid_0/1 = 0, fq_stall = 0, fq_count = 0. out_* data is don't-care.
- Enqueue-to-output latency is 1 cycle. An entry written at edge N is visible on out_* after edge N and can be dequeued in cycle N+1.
- A dequeue takes effect at the same edge. The next entry appears at head the cycle after.
- fq_stall rises the cycle after count reaches DEPTH−1 or DEPTH. It falls the cycle after a dequeue brings free entries to 2 or more.
- Flush asserted in cycle N: every output is at its reset value in cycle N+1. An enqueue in cycle N+1 is accepted normally.
- Wrap-around: with tail = DEPTH−1, a two-wide enqueue writes entries DEPTH−1 and 0. The same rule applies to head.
- Full queue with deq_en_0 and deq_en_1 set and fq_stall = 1: the dequeue proceeds and any enqueue is ignored. fq_stall drops next cycle.

## Test plan
- Reset, then enqueue {0xA, npc 0x104} and {0xB, npc 0x108} in the same cycle → next cycle out_valid_0/1 = 1, out_insn_0 = 0xA, out_insn_1 = 0xB, fq_count = 2.
- Only slot 1 valid with insn 0xC into an empty queue → out_insn_0 = 0xC, out_valid_1 = 0, fq_count = 1.
- DEPTH = 8: fill with four two-wide enqueues → fq_stall = 1 once count ≥ 7 and fq_count = 8. A fifth enqueue is ignored and contents are unchanged.
- Run 20 cycles of two-wide enqueue with single dequeue and stall honoured → dequeued sequence is in order with no loss or duplication across head/tail wrap.
- Queue holding 5 entries, with flush plus an enqueue and deq_en_0 in the same cycle → next cycle fq_count = 0, out_valid_0 = 0, fq_stall = 0.
- Queue holding 1 entry, with deq_en_0 and deq_en_1 set together with an enqueue of 2 → exactly 1 dequeued, fq_count = 2, and the new pair is at head.
